// File: rtl/w0rm_peripheral_bus_fabric.sv
// Peripheral bus fabric: address decode to one-hot slave strobes, with in-order response return.
// Optional response timeout is enabled by defining W0RM_BUS_TIMEOUT_EN.
module w0rm_peripheral_bus_fabric #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int NUM_PORTS       = 4,
    parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] BASE_ADDRS =
        {32'h80000080, 32'h80000040, 32'h80000000, 32'h00000000},
    parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] ADDR_MASKS =
        {32'hFFFFFFC0, 32'hFFFFFFC0, 32'hFFFFFFC0, 32'hFFFFF000},
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                            bus_clock,
    input  logic                            reset_n,
    input  logic                            mem_valid_i,
    input  logic                            mem_read_i,
    input  logic                            mem_write_i,
    input  logic [ADDR_WIDTH-1:0]           mem_addr_i,
    input  logic [DATA_WIDTH-1:0]           mem_data_i,
    output logic                            mem_ready_o,
    output logic                            mem_valid_o,
    output logic [DATA_WIDTH-1:0]           mem_data_o,
    output logic                            mem_error_o,
    output logic [NUM_PORTS-1:0]            slv_valid_o,
    output logic                            slv_read_o,
    output logic                            slv_write_o,
    output logic [ADDR_WIDTH-1:0]           slv_addr_o,
    output logic [DATA_WIDTH-1:0]           slv_data_o,
    input  logic [NUM_PORTS-1:0]            slv_valid_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] slv_data_i
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW = $clog2(MAX_OUTSTANDING);

    // Handshake: a request transfers in any cycle with mem_valid_i=1, a read or write
    // flag set and mem_ready_o=1; responses are single-cycle mem_valid_o strobes, in issue order.
    logic                 accept;
    logic                 dec_hit;
    logic [PW-1:0]        dec_port;

    logic [PW-1:0]        fifo_port [MAX_OUTSTANDING];
    logic                 fifo_unmapped [MAX_OUTSTANDING];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          occ;

    logic                 fifo_nonempty;
    logic [PW-1:0]        head_port;
    logic                 head_unmapped;
    logic                 head_strobe;
    logic [DATA_WIDTH-1:0] head_data;
    logic                 head_answer;
    logic                 to_hit;
    logic                 pop;
    logic                 resp_err;

    assign mem_ready_o = (occ < (AW+1)'(MAX_OUTSTANDING));
    assign accept      = mem_valid_i & (mem_read_i | mem_write_i) & mem_ready_o;

    // Lowest matching index wins because later matches are blocked by dec_hit.
    always_comb begin
        dec_hit  = 1'b0;
        dec_port = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!dec_hit &&
                ((mem_addr_i & ADDR_MASKS[p*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 BASE_ADDRS[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                dec_hit  = 1'b1;
                dec_port = PW'(p);
            end
        end
    end

    assign slv_valid_o = (accept && dec_hit) ? (NUM_PORTS'(1) << dec_port) : '0;
    assign slv_read_o  = mem_read_i;
    assign slv_write_o = mem_write_i;
    assign slv_addr_o  = mem_addr_i;
    assign slv_data_o  = mem_data_i;

    assign fifo_nonempty = (occ != '0);
    assign head_port     = fifo_port[rd_ptr];
    assign head_unmapped = fifo_unmapped[rd_ptr];

    // Only the head's own port can answer; strobes from other ports are dropped.
    always_comb begin
        head_strobe = 1'b0;
        head_data   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (PW'(p) == head_port) begin
                head_strobe = slv_valid_i[p];
                head_data   = slv_data_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign head_answer = head_unmapped | head_strobe;

`ifdef W0RM_BUS_TIMEOUT_EN
    logic [7:0] to_cnt;

    assign to_hit = fifo_nonempty & ~head_answer & (to_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge bus_clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (pop) begin
            to_cnt <= '0;
        end else if (fifo_nonempty) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    assign pop      = fifo_nonempty & (head_answer | to_hit);
    assign resp_err = head_unmapped | to_hit;

    always_ff @(posedge bus_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            mem_valid_o <= 1'b0;
            mem_data_o  <= '0;
            mem_error_o <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_port[i]     <= '0;
                fifo_unmapped[i] <= 1'b0;
            end
        end else begin
            if (accept) begin
                fifo_port[wr_ptr]     <= dec_port;
                fifo_unmapped[wr_ptr] <= ~dec_hit;
                wr_ptr                <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
            mem_valid_o <= pop;
            mem_error_o <= pop & resp_err;
            mem_data_o  <= (pop && !resp_err) ? head_data : '0;
        end
    end

endmodule

// File: doc/w0rm_peripheral_bus_fabric.md
W0RM_PERIPHERAL_BUS_FABRIC -- requirements
Module: w0rm_peripheral_bus_fabric

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter NUM_PORTS, default 4, slave port count, range 1-16.
REQ-004 SHALL have parameter BASE_ADDRS, default {32'h80000080,32'h80000040,32'h80000000,32'h00000000}, flattened NUM_PORTS*ADDR_WIDTH per-port base addresses, port 0 in the LSBs.
REQ-005 SHALL have parameter ADDR_MASKS, default {32'hFFFFFFC0,32'hFFFFFFC0,32'hFFFFFFC0,32'hFFFFF000}, flattened per-port decode masks.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 4, tracking depth, a power of two from 2 to 16.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 16, response timeout, range 2-255.
REQ-008 SHALL have one clock and an asynchronous active-low reset, exactly as follows: bus_clock in 1, sole clock; reset_n in 1, asynchronous active-low reset.
REQ-009 SHALL have the master-side ports: mem_valid_i in 1; mem_read_i in 1; mem_write_i in 1; mem_addr_i in ADDR_WIDTH; mem_data_i in DATA_WIDTH; mem_ready_o out 1, request may be accepted; mem_valid_o out 1, response strobe; mem_data_o out DATA_WIDTH, response data; mem_error_o out 1, error response.
REQ-010 SHALL have the slave-side ports: slv_valid_o out NUM_PORTS, one-hot request strobe; slv_read_o out 1; slv_write_o out 1; slv_addr_o out ADDR_WIDTH; slv_data_o out DATA_WIDTH; slv_valid_i in NUM_PORTS, per-port response strobe; slv_data_i in NUM_PORTS*DATA_WIDTH, flattened response data.

Function
REQ-011 SHALL accept a request in a cycle where mem_valid_i=1, (mem_read_i|mem_write_i)=1 and mem_ready_o=1.
REQ-012 SHALL decode port p when (mem_addr_i & mask[p]) == base[p]; when several ports match, the lowest index wins; no match marks the request UNMAPPED.
REQ-013 SHALL drive slv_valid_o, slv_read_o, slv_write_o, slv_addr_o and slv_data_o combinationally from the accepted request, with zero added latency; slv_valid_o SHALL be all-zero for UNMAPPED requests and for requests that are not accepted.
REQ-014 SHALL push each accepted request's port index and UNMAPPED flag into an in-order tracking FIFO of depth MAX_OUTSTANDING.
REQ-015 SHALL drive mem_ready_o = (registered occupancy < MAX_OUTSTANDING); a pop in the same cycle SHALL NOT raise mem_ready_o.
REQ-016 SHALL, when the FIFO head is port p and slv_valid_i[p]=1, pop the head and, on the next cycle, drive mem_valid_o=1 for exactly one cycle, with mem_data_o = slv_data_i[p] and mem_error_o=0.
REQ-017 SHALL, when the FIFO head is UNMAPPED, pop the head and, on the next cycle, drive mem_valid_o=1, mem_error_o=1 and mem_data_o=0.
REQ-018 SHALL ignore slv_valid_i strobes from any port other than the head's port.
REQ-019 SHALL support a simultaneous push and pop, leaving occupancy unchanged; FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-020 SHALL hold mem_data_o and mem_error_o at 0 while mem_valid_o=0.

Reset
REQ-021 SHALL, while reset_n=0, asynchronously clear the FIFO, occupancy and timeout counter, and force mem_valid_o=0, mem_data_o=0, mem_error_o=0 and mem_ready_o=1.
REQ-022 SHALL discard all outstanding transactions on reset assertion, issuing no responses for them after release.

Configuration
REQ-023 SHALL, when W0RM_BUS_TIMEOUT_EN is defined, count cycles while the FIFO is non-empty and the head is unanswered; the counter clears on every pop.
REQ-024 SHALL, with W0RM_BUS_TIMEOUT_EN defined, pop the head once the count reaches TIMEOUT_CYCLES and on the next cycle respond with mem_valid_o=1, mem_error_o=1, mem_data_o=0; a late response from that port is attributed to that port's next outstanding entry.
REQ-025 SHALL, without W0RM_BUS_TIMEOUT_EN, omit the counter, so an unanswered head stalls indefinitely.

Verification
REQ-026 SHALL verify decode and routing: read at 32'h80000084, port 3 answers 32'hA5 two cycles later -> slv_valid_o=4'b1000, then mem_valid_o=1, mem_data_o=32'hA5 one cycle after slv_valid_i[3].
REQ-027 SHALL verify UNMAPPED handling: read at 32'h40000000 -> slv_valid_o=0, then mem_valid_o=1, mem_error_o=1, mem_data_o=0 two cycles after accept.
REQ-028 SHALL verify ordering and full: 4 back-to-back reads to ports 1, 2, 1, 0 -> mem_ready_o=0 after the 4th; port 2 answering early is ignored; responses return in issue order.
REQ-029 SHALL verify push/pop coincidence: with occupancy 4, a pop cycle -> mem_ready_o goes 1 the following cycle; a push together with a pop at occupancy 2 keeps occupancy 2.
REQ-030 SHALL verify timeout: with W0RM_BUS_TIMEOUT_EN, read to silent port 1 -> error response 17 cycles after accept; without the macro, no response within 100 cycles.
REQ-031 SHALL verify reset: reset_n pulsed low mid-cycle with 3 outstanding -> outputs 0 immediately, and no responses after release even if slaves answer.
